// File: rtl/i_buffer_if.sv
// Fetch, issue and redirect signals between the instruction buffer and its neighbours.
// master = instruction buffer side, slave = memory/scoreboard/execute side.
`timescale 1ns/1ps
interface i_buffer_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic                  mem_req;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic                  mem_ready;
    logic [DATA_WIDTH-1:0] mem_data;
    logic                  sb_vacant_alu;
    logic                  sb_vacant_ls;
    logic                  ib_valid;
    logic [6:0]            ib_opt;
    logic [2:0]            ib_funct;
    logic [4:0]            ib_rs1;
    logic [4:0]            ib_rs2;
    logic [4:0]            ib_rd;
    logic [DATA_WIDTH-1:0] ib_imm;
    logic                  br_valid;
    logic [ADDR_WIDTH-1:0] br_target;

    modport master (
        output mem_req, mem_addr, ib_valid, ib_opt, ib_funct, ib_rs1, ib_rs2, ib_rd, ib_imm,
        input  mem_ready, mem_data, sb_vacant_alu, sb_vacant_ls, br_valid, br_target
    );

    modport slave (
        input  mem_req, mem_addr, ib_valid, ib_opt, ib_funct, ib_rs1, ib_rs2, ib_rd, ib_imm,
        output mem_ready, mem_data, sb_vacant_alu, sb_vacant_ls, br_valid, br_target
    );
endinterface

// File: rtl/i_buffer.sv
// RV32I instruction buffer: single-outstanding fetch, decode, 4-entry queue and
// class-gated issue to the scoreboard, flushed by branch redirects.
`timescale 1ns/1ps
module i_buffer #(
    parameter int                    ADDR_WIDTH     = 32,
    parameter int                    DATA_WIDTH     = 32,
    parameter int                    IB_DEPTH_WIDTH = 2,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC       = '0
) (
    input  logic       clk,
    input  logic       rst,
    i_buffer_if.master bus
);
    localparam int DEPTH = 1 << IB_DEPTH_WIDTH;
    localparam logic [6:0] OP_I = 7'b0010011;
    localparam logic [6:0] OP_L = 7'b0000011;
    localparam logic [6:0] OP_S = 7'b0100011;
    localparam logic [6:0] OP_B = 7'b1100011;
    localparam logic [6:0] OP_R = 7'b0110011;

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DISCARD} state_t;

    typedef struct packed {
        logic [6:0]            opt;
        logic [2:0]            funct;
        logic [4:0]            rs1;
        logic [4:0]            rs2;
        logic [4:0]            rd;
        logic [DATA_WIDTH-1:0] imm;
    } entry_t;

    state_t                    r_state, w_state_next;
    logic [ADDR_WIDTH-1:0]     r_pc, w_pc_next;
    logic [ADDR_WIDTH-1:0]     r_addr, w_addr_next;
    logic [IB_DEPTH_WIDTH-1:0] r_wr_ptr, r_rd_ptr;
    logic [IB_DEPTH_WIDTH:0]   r_count;
    entry_t                    r_mem [DEPTH];
    entry_t                    w_dec, w_head;
    logic                      w_supported, w_enq, w_pop, w_full, w_head_ls;
    logic [31:0]               w_inst;

    assign w_inst = bus.mem_data[31:0];

    always_comb begin
        w_dec       = '0;
        w_supported = 1'b1;
        w_dec.opt   = w_inst[6:0];
        w_dec.rd    = w_inst[11:7];
        w_dec.funct = w_inst[14:12];
        w_dec.rs1   = w_inst[19:15];
        w_dec.rs2   = w_inst[24:20];
        case (w_inst[6:0])
            OP_I, OP_L: begin
                w_dec.rs2 = '0;
                w_dec.imm = {{(DATA_WIDTH-12){w_inst[31]}}, w_inst[31:20]};
            end
            OP_S: begin
                w_dec.rd  = '0;
                w_dec.imm = {{(DATA_WIDTH-12){w_inst[31]}}, w_inst[31:25], w_inst[11:7]};
            end
            OP_B: begin
                w_dec.rd  = '0;
                w_dec.imm = {{(DATA_WIDTH-13){w_inst[31]}}, w_inst[31], w_inst[7],
                             w_inst[30:25], w_inst[11:8], 1'b0};
            end
            // funct7 travels in imm[11:5] so execute can tell ADD from SUB etc.
            OP_R:    w_dec.imm = {{(DATA_WIDTH-12){1'b0}}, w_inst[31:25], 5'b0};
            default: w_supported = 1'b0;
        endcase
    end

    assign w_full    = (r_count == (IB_DEPTH_WIDTH+1)'(DEPTH));
    assign w_enq     = (r_state == S_WAIT) && bus.mem_ready && !bus.br_valid && w_supported;
    assign w_head    = r_mem[r_rd_ptr];
    assign w_head_ls = (w_head.opt == OP_L) || (w_head.opt == OP_S);
    assign w_pop     = (r_count != '0) && !bus.br_valid &&
                       (w_head_ls ? bus.sb_vacant_ls : bus.sb_vacant_alu);

    assign bus.ib_valid = w_pop;
    assign bus.ib_opt   = w_head.opt;
    assign bus.ib_funct = w_head.funct;
    assign bus.ib_rs1   = w_head.rs1;
    assign bus.ib_rs2   = w_head.rs2;
    assign bus.ib_rd    = w_head.rd;
    assign bus.ib_imm   = w_head.imm;
    assign bus.mem_req  = (r_state != S_IDLE);
    assign bus.mem_addr = r_addr;

    always_comb begin
        w_state_next = r_state;
        w_pc_next    = r_pc;
        w_addr_next  = r_addr;
        case (r_state)
            S_IDLE: begin
                if (bus.br_valid) begin
                    w_pc_next = bus.br_target;
                end else if (!w_full) begin
                    w_state_next = S_WAIT;
                    w_addr_next  = r_pc;
                end
            end
            S_WAIT: begin
                if (bus.br_valid) begin
                    w_pc_next    = bus.br_target;
                    w_state_next = bus.mem_ready ? S_IDLE : S_DISCARD;
                end else if (bus.mem_ready) begin
                    w_pc_next    = r_pc + ADDR_WIDTH'(4);
                    w_state_next = S_IDLE;
                end
            end
            S_DISCARD: begin
                if (bus.br_valid)  w_pc_next    = bus.br_target;
                if (bus.mem_ready) w_state_next = S_IDLE;
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_pc    <= RESET_PC;
            r_addr  <= RESET_PC;
        end else begin
            r_state <= w_state_next;
            r_pc    <= w_pc_next;
            r_addr  <= w_addr_next;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (bus.br_valid) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_enq) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_enq, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Entries reset to zero so the head fields read all-zero straight out of reset.
    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
            always_ff @(posedge clk or posedge rst) begin
                if (rst)
                    r_mem[gi] <= '0;
                else if (w_enq && (r_wr_ptr == IB_DEPTH_WIDTH'(gi)))
                    r_mem[gi] <= w_dec;
            end
        end
    endgenerate
endmodule

// File: tb/tb_i_buffer.sv
// Directed bench for i_buffer: fetch/decode/issue, stalls, full queue, flush and reset.
`timescale 1ns/1ps
module tb_i_buffer;
    logic clk;
    logic rst;
    int   n_checks;
    int   n_fail;

    i_buffer_if bus ();

    i_buffer dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_req(input string name);
        int i;
        i = 0;
        while (!bus.mem_req && i < 20) begin
            step();
            i++;
        end
        n_checks++;
        if (bus.mem_req !== 1'b1) begin
            n_fail++;
            $display("FAIL %s: mem_req=%b required 1 within 20 cycles", name, bus.mem_req);
        end
    endtask

    task automatic respond(input logic [31:0] data);
        $display("mem response addr=%08h data=%08h", bus.mem_addr, data);
        bus.mem_ready = 1'b1;
        bus.mem_data  = data;
        step();
        bus.mem_ready = 1'b0;
        bus.mem_data  = '0;
    endtask

    task automatic test_reset();
        step();
        n_checks++; if (bus.mem_req !== 1'b0) begin n_fail++; $display("FAIL rst_req: got %b required 0", bus.mem_req); end
        n_checks++; if (bus.mem_addr !== 32'h0) begin n_fail++; $display("FAIL rst_addr: got %08h required 00000000", bus.mem_addr); end
        n_checks++; if (bus.ib_valid !== 1'b0) begin n_fail++; $display("FAIL rst_valid: got %b required 0", bus.ib_valid); end
        n_checks++; if ({bus.ib_opt, bus.ib_rd, bus.ib_imm} !== '0) begin n_fail++; $display("FAIL rst_fields: opt=%h rd=%h imm=%h required 0", bus.ib_opt, bus.ib_rd, bus.ib_imm); end
        rst = 1'b0;
    endtask

    task automatic test_addi();
        bus.sb_vacant_alu = 1'b1;
        wait_req("addi_req");
        n_checks++; if (bus.mem_addr !== 32'h0) begin n_fail++; $display("FAIL addi_addr: got %08h required 00000000", bus.mem_addr); end
        step();
        respond(32'h00500093);
        n_checks++; if (bus.ib_valid !== 1'b1) begin n_fail++; $display("FAIL addi_valid: got %b required 1", bus.ib_valid); end
        n_checks++; if (bus.ib_opt !== 7'h13) begin n_fail++; $display("FAIL addi_opt: got %h required 13", bus.ib_opt); end
        n_checks++; if (bus.ib_rd !== 5'd1) begin n_fail++; $display("FAIL addi_rd: got %0d required 1", bus.ib_rd); end
        n_checks++; if ({bus.ib_rs1, bus.ib_rs2, bus.ib_funct} !== 13'd0) begin n_fail++; $display("FAIL addi_regs: rs1=%0d rs2=%0d funct=%0d required 0", bus.ib_rs1, bus.ib_rs2, bus.ib_funct); end
        n_checks++; if (bus.ib_imm !== 32'd5) begin n_fail++; $display("FAIL addi_imm: got %08h required 00000005", bus.ib_imm); end
        step();
        n_checks++; if (bus.ib_valid !== 1'b0) begin n_fail++; $display("FAIL addi_popped: got %b required 0", bus.ib_valid); end
        n_checks++; if (bus.mem_req !== 1'b1 || bus.mem_addr !== 32'h4) begin n_fail++; $display("FAIL addi_next: req=%b addr=%08h required 1/00000004", bus.mem_req, bus.mem_addr); end
    endtask

    task automatic test_store_stall();
        bus.sb_vacant_ls = 1'b0;
        respond(32'hFE20AE23);
        for (int i = 0; i < 5; i++) begin
            n_checks++; if (bus.ib_valid !== 1'b0) begin n_fail++; $display("FAIL sw_stall%0d: got %b required 0", i, bus.ib_valid); end
            step();
        end
        bus.sb_vacant_ls = 1'b1;
        #1;
        n_checks++; if (bus.ib_valid !== 1'b1) begin n_fail++; $display("FAIL sw_valid: got %b required 1", bus.ib_valid); end
        n_checks++; if (bus.ib_opt !== 7'h23 || bus.ib_funct !== 3'd2) begin n_fail++; $display("FAIL sw_opt: opt=%h funct=%0d required 23/2", bus.ib_opt, bus.ib_funct); end
        n_checks++; if (bus.ib_rd !== 5'd0 || bus.ib_rs1 !== 5'd1 || bus.ib_rs2 !== 5'd2) begin n_fail++; $display("FAIL sw_regs: rd=%0d rs1=%0d rs2=%0d required 0/1/2", bus.ib_rd, bus.ib_rs1, bus.ib_rs2); end
        n_checks++; if (bus.ib_imm !== 32'hFFFFFFFC) begin n_fail++; $display("FAIL sw_imm: got %08h required fffffffc", bus.ib_imm); end
        step();
        bus.sb_vacant_ls = 1'b0;
        n_checks++; if (bus.ib_valid !== 1'b0) begin n_fail++; $display("FAIL sw_single: got %b required 0", bus.ib_valid); end
    endtask

    task automatic test_full();
        bus.sb_vacant_alu = 1'b0;
        for (int n = 0; n < 4; n++) begin
            wait_req("full_req");
            n_checks++; if (bus.mem_addr !== 32'(8 + 4*n)) begin n_fail++; $display("FAIL full_addr%0d: got %08h required %08h", n, bus.mem_addr, 32'(8 + 4*n)); end
            respond(32'h00500093);
        end
        for (int i = 0; i < 3; i++) begin
            n_checks++; if (bus.mem_req !== 1'b0) begin n_fail++; $display("FAIL full_noreq%0d: got %b required 0", i, bus.mem_req); end
            step();
        end
        bus.sb_vacant_alu = 1'b1;
        #1;
        n_checks++; if (bus.ib_valid !== 1'b1) begin n_fail++; $display("FAIL full_pop: got %b required 1", bus.ib_valid); end
        step();
        bus.sb_vacant_alu = 1'b0;
        n_checks++; if (bus.mem_req !== 1'b0) begin n_fail++; $display("FAIL full_launch_cycle: got %b required 0", bus.mem_req); end
        step();
        n_checks++; if (bus.mem_req !== 1'b1 || bus.mem_addr !== 32'd24) begin n_fail++; $display("FAIL full_fifth: req=%b addr=%08h required 1/00000018", bus.mem_req, bus.mem_addr); end
    endtask

    task automatic test_flush();
        bus.br_valid  = 1'b1;
        bus.br_target = 32'h100;
        step();
        bus.br_valid  = 1'b0;
        bus.sb_vacant_alu = 1'b1;
        #1;
        n_checks++; if (bus.ib_valid !== 1'b0) begin n_fail++; $display("FAIL flush_empty: got %b required 0", bus.ib_valid); end
        n_checks++; if (bus.mem_req !== 1'b1 || bus.mem_addr !== 32'd24) begin n_fail++; $display("FAIL flush_hold: req=%b addr=%08h required 1/00000018", bus.mem_req, bus.mem_addr); end
        step();
        step();
        respond(32'h00500093);
        n_checks++; if (bus.ib_valid !== 1'b0) begin n_fail++; $display("FAIL flush_drop: got %b required 0", bus.ib_valid); end
        step();
        n_checks++; if (bus.mem_req !== 1'b1 || bus.mem_addr !== 32'h100) begin n_fail++; $display("FAIL flush_target: req=%b addr=%08h required 1/00000100", bus.mem_req, bus.mem_addr); end
    endtask

    task automatic test_branch_unsupported();
        respond(32'hFE208CE3);
        n_checks++; if (bus.ib_valid !== 1'b1) begin n_fail++; $display("FAIL beq_valid: got %b required 1", bus.ib_valid); end
        n_checks++; if (bus.ib_opt !== 7'h63 || bus.ib_funct !== 3'd0 || bus.ib_rd !== 5'd0) begin n_fail++; $display("FAIL beq_fields: opt=%h funct=%0d rd=%0d required 63/0/0", bus.ib_opt, bus.ib_funct, bus.ib_rd); end
        n_checks++; if (bus.ib_rs1 !== 5'd1 || bus.ib_rs2 !== 5'd2) begin n_fail++; $display("FAIL beq_regs: rs1=%0d rs2=%0d required 1/2", bus.ib_rs1, bus.ib_rs2); end
        n_checks++; if (bus.ib_imm !== 32'hFFFFFFF8) begin n_fail++; $display("FAIL beq_imm: got %08h required fffffff8", bus.ib_imm); end
        step();
        n_checks++; if (bus.mem_req !== 1'b1 || bus.mem_addr !== 32'h104) begin n_fail++; $display("FAIL beq_next: req=%b addr=%08h required 1/00000104", bus.mem_req, bus.mem_addr); end
        respond(32'h0000007F);
        n_checks++; if (bus.ib_valid !== 1'b0) begin n_fail++; $display("FAIL unsup_valid: got %b required 0", bus.ib_valid); end
        step();
        n_checks++; if (bus.ib_valid !== 1'b0) begin n_fail++; $display("FAIL unsup_never: got %b required 0", bus.ib_valid); end
        n_checks++; if (bus.mem_req !== 1'b1 || bus.mem_addr !== 32'h108) begin n_fail++; $display("FAIL unsup_pc: req=%b addr=%08h required 1/00000108", bus.mem_req, bus.mem_addr); end
    endtask

    task automatic test_reset_mid();
        bus.sb_vacant_alu = 1'b0;
        respond(32'h00500093);
        wait_req("mid_req1");
        respond(32'h00500093);
        wait_req("mid_req2");
        n_checks++; if (bus.mem_addr !== 32'h110) begin n_fail++; $display("FAIL mid_addr: got %08h required 00000110", bus.mem_addr); end
        bus.sb_vacant_alu = 1'b1;
        #1;
        n_checks++; if (bus.ib_valid !== 1'b1) begin n_fail++; $display("FAIL mid_prevalid: got %b required 1", bus.ib_valid); end
        rst = 1'b1;
        #1;
        n_checks++; if (bus.ib_valid !== 1'b0) begin n_fail++; $display("FAIL mid_async_valid: got %b required 0", bus.ib_valid); end
        n_checks++; if (bus.mem_req !== 1'b0 || bus.mem_addr !== 32'h0) begin n_fail++; $display("FAIL mid_async_req: req=%b addr=%08h required 0/00000000", bus.mem_req, bus.mem_addr); end
        #2;
        rst = 1'b0;
        step();
        n_checks++; if (bus.mem_req !== 1'b1 || bus.mem_addr !== 32'h0) begin n_fail++; $display("FAIL mid_restart: req=%b addr=%08h required 1/00000000", bus.mem_req, bus.mem_addr); end
    endtask

    initial begin
        n_checks          = 0;
        n_fail            = 0;
        rst               = 1'b1;
        bus.mem_ready     = 1'b0;
        bus.mem_data      = '0;
        bus.sb_vacant_alu = 1'b0;
        bus.sb_vacant_ls  = 1'b0;
        bus.br_valid      = 1'b0;
        bus.br_target     = '0;
        test_reset();
        test_addi();
        test_store_stall();
        test_full();
        test_flush();
        test_branch_unsupported();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
